// File: rtl/bcd_operand_entry.sv
// Keypad operand entry: assembles a signed NDIGITS-digit BCD value from key events
// and hands it to the adder over a valid/ready handshake. Optional: AUTO_ENTER_EN.
module bcd_operand_entry #(
    parameter int NDIGITS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   key_code,
    input  logic                         key_vld,
    output logic [4*NDIGITS-1:0]         op_bcd,
    output logic                         op_sign,
    output logic                         op_vld,
    input  logic                         op_rdy,
    output logic [4*NDIGITS-1:0]         disp_bcd,
    output logic                         disp_sign,
    output logic [$clog2(NDIGITS+1)-1:0] digit_cnt,
    output logic                         err
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    typedef enum logic [1:0] {EMPTY, ENTRY, HOLD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    disp_bcd_q, disp_bcd_d;
    logic            disp_sign_q, disp_sign_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    op_bcd_q, op_bcd_d;
    logic            op_sign_q, op_sign_d;
    logic            op_vld_q, op_vld_d;
    logic            err_q, err_d;

    logic [W-1:0]    shiftedIn;
    logic            isDigit;
    logic            full;

    assign shiftedIn = {disp_bcd_q[W-5:0], key_code};
    assign isDigit   = (key_code <= 4'd9);
    assign full      = (cnt_q == CW'(NDIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            disp_bcd_q  <= '0;
            disp_sign_q <= 1'b0;
            cnt_q       <= '0;
            op_bcd_q    <= '0;
            op_sign_q   <= 1'b0;
            op_vld_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_sign_q <= disp_sign_d;
            cnt_q       <= cnt_d;
            op_bcd_q    <= op_bcd_d;
            op_sign_q   <= op_sign_d;
            op_vld_q    <= op_vld_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        disp_bcd_d  = disp_bcd_q;
        disp_sign_d = disp_sign_q;
        cnt_d       = cnt_q;
        op_bcd_d    = op_bcd_q;
        op_sign_d   = op_sign_q;
        op_vld_d    = op_vld_q;
        err_d       = 1'b0;

        if (state_q == HOLD) begin
            // A transfer wins over any key; only CLEAR is accepted alongside it.
            if (op_rdy) begin
                op_vld_d    = 1'b0;
                disp_bcd_d  = '0;
                disp_sign_d = 1'b0;
                cnt_d       = '0;
                state_d     = EMPTY;
                err_d       = key_vld && (key_code != KEY_CLEAR);
            end else if (key_vld) begin
                if (key_code == KEY_CLEAR) begin
                    op_vld_d    = 1'b0;
                    disp_bcd_d  = '0;
                    disp_sign_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = EMPTY;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (key_vld) begin
            if (isDigit) begin
                if (full) begin
                    err_d = 1'b1;
                end else if (!(key_code == 4'd0 && cnt_q == '0)) begin
                    disp_bcd_d = shiftedIn;
                    cnt_d      = cnt_q + CW'(1);
`ifdef AUTO_ENTER_EN
                    if (cnt_q == CW'(NDIGITS - 1)) begin
                        op_bcd_d  = shiftedIn;
                        op_sign_d = disp_sign_q & (shiftedIn != '0);
                        op_vld_d  = 1'b1;
                    end
`endif
                end
            end else begin
                unique case (key_code)
                    KEY_SIGN: disp_sign_d = ~disp_sign_q;
                    KEY_BKSP: begin
                        if (cnt_q != '0) begin
                            disp_bcd_d = {4'd0, disp_bcd_q[W-1:4]};
                            cnt_d      = cnt_q - CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    KEY_CLEAR: begin
                        disp_bcd_d  = '0;
                        disp_sign_d = 1'b0;
                        cnt_d       = '0;
                    end
                    KEY_ENTER: begin
                        op_bcd_d  = disp_bcd_q;
                        op_sign_d = disp_sign_q & (disp_bcd_q != '0);
                        op_vld_d  = 1'b1;
                    end
                    default: err_d = 1'b1;
                endcase
            end

            if (op_vld_d) begin
                state_d = HOLD;
            end else if (cnt_d != '0 || disp_sign_d) begin
                state_d = ENTRY;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_comb begin
        op_bcd    = op_bcd_q;
        op_sign   = op_sign_q;
        op_vld    = op_vld_q;
        disp_bcd  = disp_bcd_q;
        disp_sign = disp_sign_q;
        digit_cnt = cnt_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Self-checking bench for bcd_operand_entry: directed test-plan steps followed by
// random key traffic, all checked against a decimal-arithmetic reference model.
module tb_bcd_operand_entry;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  key_code = 4'd0;
    logic        key_vld = 1'b0;
    logic        op_rdy = 1'b0;
    logic [11:0] op_bcd;
    logic        op_sign;
    logic        op_vld;
    logic [11:0] disp_bcd;
    logic        disp_sign;
    logic [1:0]  digit_cnt;
    logic        err;

    int checks = 0;
    int failures = 0;

    int mMag = 0;
    int mCnt = 0;
    int mOpMag = 0;
    bit mSign = 0;
    bit mHold = 0;
    bit mOpSign = 0;
    bit mErr = 0;

    bcd_operand_entry #(.NDIGITS(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_code(key_code),
        .key_vld(key_vld),
        .op_bcd(op_bcd),
        .op_sign(op_sign),
        .op_vld(op_vld),
        .op_rdy(op_rdy),
        .disp_bcd(disp_bcd),
        .disp_sign(disp_sign),
        .digit_cnt(digit_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] toBcd(input int value);
        logic [11:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear();
        mMag = 0;
        mCnt = 0;
        mSign = 0;
    endtask

    task automatic modelEnter();
        mOpMag = mMag;
        mOpSign = mSign && (mMag != 0);
        mHold = 1;
    endtask

    task automatic modelReset();
        modelClear();
        mOpMag = 0;
        mOpSign = 0;
        mHold = 0;
        mErr = 0;
    endtask

    task automatic modelStep(input bit vld, input int code, input bit rdy);
        mErr = 0;
        if (mHold) begin
            if (rdy) begin
                mHold = 0;
                modelClear();
                if (vld && code != 12) mErr = 1;
            end else if (vld) begin
                if (code == 12) begin
                    mHold = 0;
                    modelClear();
                end else begin
                    mErr = 1;
                end
            end
        end else if (vld) begin
            if (code <= 9) begin
                if (mCnt == N) mErr = 1;
                else if (!(code == 0 && mCnt == 0)) begin
                    mMag = mMag * 10 + code;
                    mCnt++;
`ifdef AUTO_ENTER_EN
                    if (mCnt == N) modelEnter();
`endif
                end
            end else if (code == 10) mSign = !mSign;
            else if (code == 11) begin
                if (mCnt > 0) begin
                    mMag = mMag / 10;
                    mCnt--;
                end else mErr = 1;
            end else if (code == 12) modelClear();
            else if (code == 13) modelEnter();
            else mErr = 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".disp_bcd"}, 32'(disp_bcd), 32'(toBcd(mMag)));
        compare({tag, ".disp_sign"}, 32'(disp_sign), 32'(mSign));
        compare({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(mCnt));
        compare({tag, ".err"}, 32'(err), 32'(mErr));
        compare({tag, ".op_vld"}, 32'(op_vld), 32'(mHold));
        if (mHold) begin
            compare({tag, ".op_bcd"}, 32'(op_bcd), 32'(toBcd(mOpMag)));
            compare({tag, ".op_sign"}, 32'(op_sign), 32'(mOpSign));
        end
    endtask

    task automatic applyStimulus(input bit vld, input logic [3:0] code, input bit rdy, input string tag);
        key_vld = vld;
        key_code = code;
        op_rdy = rdy;
        @(posedge clk);
        #1;
        modelStep(vld, int'(code), rdy);
        key_vld = 1'b0;
        checkOutput(tag);
    endtask

    task automatic checkAllZero(input string tag);
        compare({tag, ".op_bcd"}, 32'(op_bcd), 32'd0);
        compare({tag, ".op_sign"}, 32'(op_sign), 32'd0);
        compare({tag, ".op_vld"}, 32'(op_vld), 32'd0);
        compare({tag, ".disp_bcd"}, 32'(disp_bcd), 32'd0);
        compare({tag, ".disp_sign"}, 32'(disp_sign), 32'd0);
        compare({tag, ".digit_cnt"}, 32'(digit_cnt), 32'd0);
        compare({tag, ".err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAllZero("reset");
        #5 rst_n = 1'b1;

        // Basic entry and immediate transfer with op_rdy already high.
        applyStimulus(1, 4'd1, 0, "k1");
        applyStimulus(1, 4'd2, 0, "k2");
        applyStimulus(1, 4'd3, 0, "k3");
        compare("plan.disp123", 32'(disp_bcd), 32'h123);
        applyStimulus(1, 4'hD, 1, "enter123");
        compare("plan.op123", 32'(op_bcd), 32'h123);
        applyStimulus(0, 4'd0, 1, "xfer123");

        // Negative operand with leading zero and stalled consumer.
        applyStimulus(1, 4'hA, 0, "sign");
        applyStimulus(1, 4'd0, 0, "lead0");
        applyStimulus(1, 4'd4, 0, "k4");
        applyStimulus(1, 4'd5, 0, "k5");
        applyStimulus(1, 4'hD, 0, "enter045");
        for (int i = 0; i < 5; i++) applyStimulus(0, 4'd0, 0, "stall");
        compare("plan.op045", 32'({op_sign, op_bcd}), 32'h1045);
        applyStimulus(0, 4'd0, 1, "xfer045");

        // Overflow digit (or auto-enter on the third digit).
        applyStimulus(1, 4'd7, 0, "k7");
        applyStimulus(1, 4'd8, 0, "k8");
        applyStimulus(1, 4'd9, 0, "k9");
        applyStimulus(1, 4'd4, 0, "k4over");
        compare("plan.disp789", 32'(disp_bcd), 32'h789);
        applyStimulus(1, 4'hC, 0, "clr789");

        // Negative zero normalisation; backspace on empty keeps sign.
        applyStimulus(1, 4'hA, 0, "signz");
        applyStimulus(1, 4'hD, 0, "enterz");
        applyStimulus(0, 4'd0, 1, "xferz");
        applyStimulus(1, 4'hB, 0, "bkspEmpty");
        applyStimulus(1, 4'hA, 0, "signb");
        applyStimulus(1, 4'hB, 0, "bkspSigned");
        applyStimulus(1, 4'hC, 0, "clrb");

        // Keys in HOLD, CLEAR in HOLD, backspace.
        applyStimulus(1, 4'd6, 0, "k6");
        applyStimulus(1, 4'hD, 0, "enter6");
        applyStimulus(1, 4'd5, 0, "holdDigit");
        applyStimulus(1, 4'hE, 0, "holdIllegal");
        applyStimulus(1, 4'hC, 0, "holdClear");
        applyStimulus(1, 4'd3, 0, "k3b");
        applyStimulus(1, 4'd4, 0, "k4b");
        applyStimulus(1, 4'hB, 0, "bksp34");
        compare("plan.disp003", 32'(disp_bcd), 32'h003);

        // Keys during the transfer cycle, including CLEAR.
        applyStimulus(1, 4'hD, 1, "enterRdy");
        applyStimulus(1, 4'd2, 1, "xferKey");
        applyStimulus(1, 4'd8, 0, "k8b");
        applyStimulus(1, 4'hD, 0, "enter8");
        applyStimulus(1, 4'hC, 1, "xferClear");

        // Asynchronous reset while holding an operand.
        applyStimulus(1, 4'd9, 0, "k9r");
        applyStimulus(1, 4'hD, 0, "enter9r");
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAllZero("asyncReset");
        #2 rst_n = 1'b1;
        applyStimulus(1, 4'd6, 0, "afterReset");

        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_operand_entry.md
# bcd_operand_entry

Keypad-side operand entry for the signed 3-digit BCD adder/subtractor: the input end of the datapath, opposite the seven-segment output end. Accepts single-cycle key events, assembles an N-digit BCD magnitude with a sign, and drives a live display copy. On ENTER it presents the finished operand to the adder with a valid/ready handshake.

## Interface
Parameters:
- NDIGITS, 3, number of BCD digits; magnitude width is 4*NDIGITS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- key_code  in  4  key value: 0-9 digit, 4'hA SIGN, 4'hB BACKSPACE, 4'hC CLEAR, 4'hD ENTER, 4'hE/4'hF illegal.
- key_vld  in  1  single-cycle key event strobe.
- op_bcd  out  4*NDIGITS  latched operand magnitude, most significant digit in the top nibble.
- op_sign  out  1  latched operand sign, 1 = negative.
- op_vld  out  1  operand valid.
- op_rdy  in  1  consumer ready.
- disp_bcd  out  4*NDIGITS  live entry magnitude.
- disp_sign  out  1  live entry sign.
- digit_cnt  out  $clog2(NDIGITS+1)  significant digits entered.
- err  out  1  one-cycle pulse on a rejected key.

## Operation
- States:
  - EMPTY: digit_cnt = 0.
  - ENTRY: digit_cnt > 0 or disp_sign = 1.
  - HOLD: op_vld = 1.
- Digit key, EMPTY/ENTRY:
  - Digit 0 with digit_cnt = 0: no change. Leading zeros are not counted.
  - Any other digit with digit_cnt < NDIGITS: disp_bcd shifts left by 4, the new digit enters the LSD, digit_cnt increments, state becomes ENTRY.
  - Digit with digit_cnt = NDIGITS: ignored, err pulses.
- SIGN: toggles disp_sign in EMPTY/ENTRY. State becomes ENTRY if disp_sign becomes 1; becomes EMPTY if disp_sign becomes 0 and digit_cnt = 0.
- BACKSPACE:
  - digit_cnt > 0: disp_bcd shifts right by 4 with zero fill, digit_cnt decrements.
  - digit_cnt = 0: err pulses; sign is unchanged.
- CLEAR: disp_bcd, disp_sign and digit_cnt go to 0 and the state becomes EMPTY. In HOLD, CLEAR also drops op_vld and abandons the operand.
- ENTER, EMPTY/ENTRY:
  - op_bcd <= disp_bcd.
  - op_sign <= disp_sign & (disp_bcd != 0). Negative zero is normalised to +0.
  - op_vld <= 1; state becomes HOLD.
- Illegal codes: ignored with err in every state.
- HOLD:
  - Digit, SIGN, BACKSPACE and ENTER are ignored and pulse err.
  - op_bcd/op_sign stay stable while op_vld = 1.
  - Transfer happens on the edge where op_vld & op_rdy. On that edge op_vld clears, disp_* and digit_cnt clear, and state becomes EMPTY.
- op_rdy is ignored outside HOLD.

## Timing
- Reset value of every output is 0; state is EMPTY.
- Every output is registered. A key at edge k is visible on disp_*/digit_cnt/err after edge k. ENTER at edge k gives op_vld = 1 after edge k.
- err is high for exactly one cycle per rejected key.
- A key arriving in the transfer cycle (op_vld & op_rdy) is ignored with err, except CLEAR. CLEAR plus transfer in the same cycle counts as a completed transfer; both lead to EMPTY.
- op_rdy may be high before op_vld. The transfer then completes one cycle after op_vld rises, i.e. minimum one cycle in HOLD.
- rst_n low at any time, including HOLD, clears everything asynchronously. The pending operand is lost.

## Configuration
- AUTO_ENTER_EN defined: the digit that makes digit_cnt = NDIGITS also performs ENTER in the same cycle. op_bcd holds the full value, op_vld rises after that edge, and the state goes straight to HOLD.
- Not defined: the state stays in ENTRY with a full count; further digits pulse err until ENTER, BACKSPACE or CLEAR.

## Test plan
- Reset, then keys 1,2,3, ENTER with op_rdy=1 -> disp_bcd 12'h123, digit_cnt 3; op_vld one cycle with op_bcd 12'h123, op_sign 0; then EMPTY.
- Keys SIGN,0,4,5, ENTER, op_rdy held low 5 cycles then high -> op_bcd 12'h045, op_sign 1; op_vld high for all 5 stall cycles and clears on the edge after op_rdy rises.
- Keys 7,8,9,4 without AUTO_ENTER_EN -> 4th digit ignored, err pulse, disp_bcd 12'h789. With AUTO_ENTER_EN, keys 7,8,9 -> op_vld rises after the 9, op_bcd 12'h789.
- SIGN, ENTER -> op_bcd 0, op_sign 0 (no negative zero); BACKSPACE in EMPTY -> err, disp_sign unchanged.
- In HOLD, key 5 -> err, op_bcd unchanged. CLEAR in HOLD -> op_vld 0, state EMPTY. Keys 3,4, BACKSPACE -> disp_bcd 12'h003, digit_cnt 1.
- Assert rst_n low mid-HOLD -> all outputs 0 immediately, without waiting for a clock edge; first key after release is accepted.
